// File: rtl/video_timing_gen_if.sv
// Configuration inputs and timing outputs of the video timing generator.
// master = generator side, slave = configuration/sink side.
interface video_timing_gen_if #(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13
);
    logic              enable;
    logic [X_BITS-1:0] h_active;
    logic [X_BITS-1:0] h_fp;
    logic [X_BITS-1:0] h_sync;
    logic [X_BITS-1:0] h_bp;
    logic [Y_BITS-1:0] v_active;
    logic [Y_BITS-1:0] v_fp;
    logic [Y_BITS-1:0] v_sync;
    logic [Y_BITS-1:0] v_bp;
    logic              hs_pol;
    logic              vs_pol;
    logic              hn_out;
    logic              vn_out;
    logic              den_out;
    logic [X_BITS-1:0] x_out;
    logic [Y_BITS-1:0] y_out;
    logic [X_BITS-1:0] total_active_pix;
    logic [Y_BITS-1:0] total_active_lines;
    logic              frame_start;
    logic              config_err;

    modport master (
        input  enable, h_active, h_fp, h_sync, h_bp,
        input  v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol,
        output hn_out, vn_out, den_out, x_out, y_out,
        output total_active_pix, total_active_lines, frame_start, config_err
    );

    modport slave (
        output enable, h_active, h_fp, h_sync, h_bp,
        output v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol,
        input  hn_out, vn_out, den_out, x_out, y_out,
        input  total_active_pix, total_active_lines, frame_start, config_err
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: shadowed config, h/v counters, registered sync/DE/coords.
// One cycle from counters to outputs; enable and config only take effect in IDLE or at frame end.
module video_timing_gen #(
    parameter int X_BITS = 13,
    parameter int Y_BITS = 13
) (
    input  logic               clk_in,
    input  logic               reset,
    video_timing_gen_if.master vif
);
    localparam int XW = X_BITS + 2;
    localparam int YW = Y_BITS + 2;
    localparam logic [XW-1:0] X_MAX = {2'b00, {X_BITS{1'b1}}};
    localparam logic [YW-1:0] Y_MAX = {2'b00, {Y_BITS{1'b1}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [X_BITS-1:0] h_cnt_q, h_cnt_d;
    logic [Y_BITS-1:0] v_cnt_q, v_cnt_d;
    logic [X_BITS-1:0] h_act_q, h_fp_q, h_sync_q, h_bp_q;
    logic [Y_BITS-1:0] v_act_q, v_fp_q, v_sync_q, v_bp_q;
    logic              hs_pol_q, vs_pol_q, err_q;
    logic              hn_q, hn_d, vn_q, vn_d, den_q, den_d, fs_q, fs_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic              load;

    // Candidate configuration straight from the inputs, widened so nothing truncates.
    logic [XW-1:0] h_tot_c;
    logic [YW-1:0] v_tot_c;
    logic          cand_err;
    assign h_tot_c = {2'b00, vif.h_active} + {2'b00, vif.h_fp} + {2'b00, vif.h_sync} + {2'b00, vif.h_bp};
    assign v_tot_c = {2'b00, vif.v_active} + {2'b00, vif.v_fp} + {2'b00, vif.v_sync} + {2'b00, vif.v_bp};
    assign cand_err = (vif.h_active == '0) || (vif.h_sync == '0) ||
                      (vif.v_active == '0) || (vif.v_sync == '0) ||
                      (h_tot_c > X_MAX) || (v_tot_c > Y_MAX);

    logic [XW-1:0] h_tot_s, hs_start, hs_end, hx;
    logic [YW-1:0] v_tot_s, vs_start, vs_end, vy;
    logic          h_last, v_last, frame_last, hsync_c, vsync_c, de_c, v_in;
    assign hx       = {2'b00, h_cnt_q};
    assign vy       = {2'b00, v_cnt_q};
    assign hs_start = {2'b00, h_act_q} + {2'b00, h_fp_q};
    assign hs_end   = hs_start + {2'b00, h_sync_q};
    assign h_tot_s  = hs_end + {2'b00, h_bp_q};
    assign vs_start = {2'b00, v_act_q} + {2'b00, v_fp_q};
    assign vs_end   = vs_start + {2'b00, v_sync_q};
    assign v_tot_s  = vs_end + {2'b00, v_bp_q};

    assign h_last     = (hx == h_tot_s - XW'(1));
    assign v_last     = (vy == v_tot_s - YW'(1));
    assign frame_last = h_last && v_last;
    assign hsync_c    = (hx >= hs_start) && (hx < hs_end);
    assign vsync_c    = (vy >= vs_start) && (vy < vs_end);
    assign v_in       = (v_cnt_q < v_act_q);
    assign de_c       = (h_cnt_q < h_act_q) && v_in;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        h_cnt_d = '0;
        v_cnt_d = '0;
        hn_d    = ~hs_pol_q;
        vn_d    = ~vs_pol_q;
        den_d   = 1'b0;
        x_d     = '0;
        y_d     = '0;
        fs_d    = 1'b0;
        case (state_q)
            IDLE: begin
                load = 1'b1;
                if (vif.enable && !cand_err) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                hn_d  = hsync_c ~^ hs_pol_q;
                vn_d  = vsync_c ~^ vs_pol_q;
                den_d = de_c;
                x_d   = de_c ? h_cnt_q : '0;
                y_d   = v_in ? v_cnt_q : '0;
                fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
                if (!h_last) begin
                    h_cnt_d = h_cnt_q + X_BITS'(1);
                    v_cnt_d = v_cnt_q;
                end else begin
                    v_cnt_d = v_last ? '0 : v_cnt_q + Y_BITS'(1);
                end
                // The frame always completes; enable and new config are only honoured here.
                if (frame_last) begin
                    load = 1'b1;
                    if (!vif.enable || cand_err) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_act_q  <= '0;
            h_fp_q   <= '0;
            h_sync_q <= '0;
            h_bp_q   <= '0;
            v_act_q  <= '0;
            v_fp_q   <= '0;
            v_sync_q <= '0;
            v_bp_q   <= '0;
            hs_pol_q <= 1'b0;
            vs_pol_q <= 1'b0;
            err_q    <= 1'b0;
            hn_q     <= 1'b0;
            vn_q     <= 1'b0;
            den_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            fs_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hn_q    <= hn_d;
            vn_q    <= vn_d;
            den_q   <= den_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            if (load) begin
                h_act_q  <= vif.h_active;
                h_fp_q   <= vif.h_fp;
                h_sync_q <= vif.h_sync;
                h_bp_q   <= vif.h_bp;
                v_act_q  <= vif.v_active;
                v_fp_q   <= vif.v_fp;
                v_sync_q <= vif.v_sync;
                v_bp_q   <= vif.v_bp;
                hs_pol_q <= vif.hs_pol;
                vs_pol_q <= vif.vs_pol;
                err_q    <= cand_err;
            end
        end
    end

    assign vif.hn_out             = hn_q;
    assign vif.vn_out             = vn_q;
    assign vif.den_out            = den_q;
    assign vif.x_out              = x_q;
    assign vif.y_out              = y_q;
    assign vif.frame_start        = fs_q;
    assign vif.total_active_pix   = h_act_q;
    assign vif.total_active_lines = v_act_q;
    assign vif.config_err         = err_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position reference model feeding a per-cycle scoreboard,
// a table of frame scenarios with hand-derived totals, and hand-written reset/boundary sequences.
module tb_video_timing_gen;
    localparam int XB = 13;
    localparam int YB = 13;

    typedef struct packed {
        logic [XB-1:0] ha, hfp, hs, hbp;
        logic [YB-1:0] va, vfp, vs, vbp;
        logic          hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic          hn, vn, den, fs, err;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [XB-1:0] tap;
        logic [YB-1:0] tal;
    } out_t;

    typedef struct {
        cfg_t cfg;
        cfg_t alt;
        int   sw;
        int   drop;
        int   n;
        int   e_den, e_fs, e_hn, e_vn;
    } scen_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if #(.X_BITS(XB), .Y_BITS(YB)) vif ();
    video_timing_gen #(.X_BITS(XB), .Y_BITS(YB)) dut (
        .clk_in (clk),
        .reset  (rst),
        .vif    (vif.master)
    );

    int   checks = 0;
    int   errors = 0;
    int   cnt_den, cnt_fs, cnt_hn, cnt_vn;
    out_t exp_q[$];

    bit   m_run;
    int   m_p;
    cfg_t m_cfg;

    function automatic cfg_t mk(int ha, int hfp, int hs, int hbp, int va, int vfp, int vs, int vbp,
                                int hp, int vp);
        cfg_t c;
        c.ha = XB'(ha); c.hfp = XB'(hfp); c.hs = XB'(hs); c.hbp = XB'(hbp);
        c.va = YB'(va); c.vfp = YB'(vfp); c.vs = YB'(vs); c.vbp = YB'(vbp);
        c.hpol = hp[0]; c.vpol = vp[0];
        return c;
    endfunction

    function automatic int htot(cfg_t c);
        return int'(c.ha) + int'(c.hfp) + int'(c.hs) + int'(c.hbp);
    endfunction

    function automatic int vtot(cfg_t c);
        return int'(c.va) + int'(c.vfp) + int'(c.vs) + int'(c.vbp);
    endfunction

    function automatic bit cfg_ok(cfg_t c);
        return (c.ha != 0) && (c.hs != 0) && (c.va != 0) && (c.vs != 0) &&
               (htot(c) <= (1 << XB) - 1) && (vtot(c) <= (1 << YB) - 1);
    endfunction

    // Expected registered outputs derived from the position within the frame.
    function automatic out_t model_out();
        out_t o;
        int   h, v, hs0, vs0;
        bit   de;
        o = '0;
        if (!m_run) begin
            o.hn = ~m_cfg.hpol;
            o.vn = ~m_cfg.vpol;
        end else begin
            h   = m_p % htot(m_cfg);
            v   = m_p / htot(m_cfg);
            hs0 = int'(m_cfg.ha) + int'(m_cfg.hfp);
            vs0 = int'(m_cfg.va) + int'(m_cfg.vfp);
            o.hn = ((h >= hs0) && (h < hs0 + int'(m_cfg.hs))) ? m_cfg.hpol : ~m_cfg.hpol;
            o.vn = ((v >= vs0) && (v < vs0 + int'(m_cfg.vs))) ? m_cfg.vpol : ~m_cfg.vpol;
            de   = (h < int'(m_cfg.ha)) && (v < int'(m_cfg.va));
            o.den = de;
            o.x   = de ? XB'(h) : '0;
            o.y   = (v < int'(m_cfg.va)) ? YB'(v) : '0;
            o.fs  = (m_p == 0);
        end
        return o;
    endfunction

    task automatic model_step(cfg_t c, logic en);
        if (!m_run) begin
            m_cfg = c;
            if (en && cfg_ok(c)) begin
                m_run = 1'b1;
                m_p   = 0;
            end
        end else if (m_p == htot(m_cfg) * vtot(m_cfg) - 1) begin
            m_cfg = c;
            m_p   = 0;
            if (!en || !cfg_ok(c)) m_run = 1'b0;
        end else begin
            m_p++;
        end
    endtask

    task automatic chk(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_out();
        out_t e, a;
        if (exp_q.size() == 0) return;
        e     = exp_q.pop_front();
        a.hn  = vif.hn_out;
        a.vn  = vif.vn_out;
        a.den = vif.den_out;
        a.fs  = vif.frame_start;
        a.err = vif.config_err;
        a.x   = vif.x_out;
        a.y   = vif.y_out;
        a.tap = vif.total_active_pix;
        a.tal = vif.total_active_lines;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outputs @%0t: actual hn=%b vn=%b den=%b fs=%b err=%b x=%0d y=%0d tap=%0d tal=%0d, required hn=%b vn=%b den=%b fs=%b err=%b x=%0d y=%0d tap=%0d tal=%0d",
                     $time, a.hn, a.vn, a.den, a.fs, a.err, a.x, a.y, a.tap, a.tal,
                     e.hn, e.vn, e.den, e.fs, e.err, e.x, e.y, e.tap, e.tal);
        end
        cnt_den += int'(a.den);
        cnt_fs  += int'(a.fs);
        cnt_hn  += int'(a.hn);
        cnt_vn  += int'(a.vn);
    endtask

    // One clock: check last cycle's output, drive this cycle's inputs, queue what they must produce.
    task automatic cycle(cfg_t c, logic en);
        out_t e;
        check_out();
        vif.enable   = en;
        vif.h_active = c.ha;  vif.h_fp = c.hfp; vif.h_sync = c.hs; vif.h_bp = c.hbp;
        vif.v_active = c.va;  vif.v_fp = c.vfp; vif.v_sync = c.vs; vif.v_bp = c.vbp;
        vif.hs_pol   = c.hpol;
        vif.vs_pol   = c.vpol;
        e = model_out();
        model_step(c, en);
        e.err = !cfg_ok(m_cfg);
        e.tap = m_cfg.ha;
        e.tal = m_cfg.va;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_zero(string name);
        chk({name, "_hn"},  int'(vif.hn_out), 0);
        chk({name, "_vn"},  int'(vif.vn_out), 0);
        chk({name, "_den"}, int'(vif.den_out), 0);
        chk({name, "_fs"},  int'(vif.frame_start), 0);
        chk({name, "_xy"},  int'(vif.x_out) + int'(vif.y_out), 0);
        chk({name, "_tot"}, int'(vif.total_active_pix) + int'(vif.total_active_lines) +
                            int'(vif.config_err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        outputs_zero("reset");
        exp_q.delete();
        m_run = 1'b0;
        m_p   = 0;
        m_cfg = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    scen_t tbl[6];
    cfg_t  base;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        base = mk(4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
        tbl[0] = '{base, base, -1, -1, 97, 24, 2, 24, 16};
        tbl[1] = '{mk(4, 1, 2, 1, 3, 1, 1, 1, 0, 0), mk(4, 1, 2, 1, 3, 1, 1, 1, 0, 0),
                   -1, -1, 97, 24, 2, 74, 82};
        tbl[2] = '{base, base, -1, 11, 97, 12, 1, 12, 8};
        tbl[3] = '{base, mk(6, 1, 2, 1, 3, 1, 1, 1, 1, 1), 21, -1, 109, 30, 2, 24, 18};
        tbl[4] = '{mk(2, 0, 1, 0, 1, 0, 1, 0, 1, 1), mk(2, 0, 1, 0, 1, 0, 1, 0, 1, 1),
                   -1, -1, 13, 4, 2, 4, 6};
        tbl[5] = '{mk(4, 1, 0, 1, 3, 1, 1, 1, 1, 1), base, 10, -1, 59, 12, 1, 12, 8};

        vif.enable = 1'b0;
        vif.h_active = '0; vif.h_fp = '0; vif.h_sync = '0; vif.h_bp = '0;
        vif.v_active = '0; vif.v_fp = '0; vif.v_sync = '0; vif.v_bp = '0;
        vif.hs_pol = 1'b0; vif.vs_pol = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int k = 0; k < 3; k++) cycle(tbl[i].cfg, 1'b0);
            cnt_den = 0; cnt_fs = 0; cnt_hn = 0; cnt_vn = 0;
            for (int k = 0; k < tbl[i].n; k++) begin
                cycle((tbl[i].sw >= 0 && k >= tbl[i].sw) ? tbl[i].alt : tbl[i].cfg,
                      !(tbl[i].drop >= 0 && k >= tbl[i].drop));
            end
            check_out();
            chk($sformatf("scen%0d_den_count", i), cnt_den, tbl[i].e_den);
            chk($sformatf("scen%0d_frame_starts", i), cnt_fs, tbl[i].e_fs);
            chk($sformatf("scen%0d_hn_high", i), cnt_hn, tbl[i].e_hn);
            chk($sformatf("scen%0d_vn_high", i), cnt_vn, tbl[i].e_vn);
        end

        // Largest legal totals versus one past the limit.
        do_reset();
        cycle(mk(8189, 0, 1, 1, 3, 1, 1, 1, 1, 1), 1'b0);
        cycle(mk(8189, 0, 1, 1, 3, 1, 1, 1, 1, 1), 1'b0);
        chk("h_total_max_ok", int'(vif.config_err), 0);
        cycle(mk(8189, 0, 1, 2, 3, 1, 1, 1, 1, 1), 1'b0);
        cycle(mk(8189, 0, 1, 2, 3, 1, 1, 1, 1, 1), 1'b0);
        chk("h_total_over_err", int'(vif.config_err), 1);
        cycle(mk(4, 1, 2, 1, 8189, 1, 1, 1, 1, 1), 1'b0);
        cycle(mk(4, 1, 2, 1, 8189, 1, 1, 1, 1, 1), 1'b0);
        chk("v_total_over_err", int'(vif.config_err), 1);
        check_out();

        // Reset in the middle of a running frame, then restart.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(base, 1'b0);
        for (int k = 0; k < 31; k++) cycle(base, 1'b1);
        chk("pre_reset_hn_active", int'(vif.hn_out), 1);
        #2;
        rst = 1'b1;
        #1;
        outputs_zero("midframe_reset");
        exp_q.delete();
        m_run = 1'b0;
        m_p   = 0;
        m_cfg = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(base, 1'b1);
        cycle(base, 1'b1);
        chk("restart_frame_start_n2", int'(vif.frame_start), 1);
        chk("restart_den_n2", int'(vif.den_out), 1);
        for (int k = 0; k < 10; k++) cycle(base, 1'b1);
        check_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
